// File: rtl/dramctl_multi_if.sv
// Bus bundle between the 68030 side (decoder, CPU strobes) and the DRAM controller,
// including the SIMM-facing strobes and the DSACK/BERR returns.
interface dramctl_multi_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int MA_BITS    = 12,
    parameter int NUM_SIMMS  = 2
);
    logic                   nCS;
    logic                   RnW;
    logic                   nAS;
    logic                   SIZ0;
    logic                   SIZ1;
    logic [ADDR_WIDTH-1:0]  ADDR;
    logic                   DRAM_nWR;
    logic [MA_BITS-1:0]     DRAM_ADDR;
    logic [4*NUM_SIMMS-1:0] DRAM_nRAS;
    logic [3:0]             DRAM_nCAS;
    logic                   DSACK0;
    logic                   DSACK1;
    logic                   BERR;

    modport master (
        output nCS, RnW, nAS, SIZ0, SIZ1, ADDR,
        input  DRAM_nWR, DRAM_ADDR, DRAM_nRAS, DRAM_nCAS, DSACK0, DSACK1, BERR
    );

    modport slave (
        input  nCS, RnW, nAS, SIZ0, SIZ1, ADDR,
        output DRAM_nWR, DRAM_ADDR, DRAM_nRAS, DRAM_nCAS, DSACK0, DSACK1, BERR
    );
endinterface

// File: rtl/dramctl_multi.sv
// FPM/EDO DRAM controller for the 68030: 1..4 SIMMs, one or two sides each,
// queued CAS-before-RAS refresh, CAS wait states, multi-cycle precharge and
// bus error for accesses beyond populated memory. All DRAM strobes are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for refresh demand or a fresh nAS/nCS access
// RW1       | drive row address
// RW2       | assert the two nRAS lines of the selected SIMM side
// RW3       | drive column address, nWR follows RnW
// RW4       | assert byte-lane nCAS
// CASWAIT   | hold CAS for CAS_WAIT extra clocks
// RW5       | DSACK asserted until nAS returns high
// REFRESH1  | nCAS all low (CAS-before-RAS)
// REFRESH2  | nRAS all low
// REFRESH3  | nCAS all high
// REFRESH4  | nRAS all high
// ERR       | BERR asserted until nAS returns high
// PRECHARGE | strobes idle for PRECHARGE_CYCLES clocks
module dramctl_multi #(
    parameter int ADDR_WIDTH       = 28,
    parameter int MA_BITS          = 12,
    parameter int NUM_SIMMS        = 2,
    parameter int SIDES            = 2,
    parameter int REFRESH_CNT      = 375,
    parameter int CAS_WAIT         = 0,
    parameter int PRECHARGE_CYCLES = 1
) (
    input  logic           CLK,
    input  logic           nRST,
    dramctl_multi_if.slave bus
);
    localparam int BANK_LSB = 2 + 2 * MA_BITS;
    localparam int BANK_W   = ADDR_WIDTH - BANK_LSB;
    localparam int NR       = 4 * NUM_SIMMS;
    localparam int RC_W     = $clog2(REFRESH_CNT + 1);

    localparam logic [BANK_W+3:0] NBANKS  = (BANK_W + 4)'(NUM_SIMMS * SIDES);
    localparam logic [RC_W-1:0]   RC_LAST = RC_W'(REFRESH_CNT - 1);
    localparam logic [1:0]        CW_LAST = 2'(CAS_WAIT - 1);
    localparam logic [1:0]        PC_LAST = 2'(PRECHARGE_CYCLES - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RW1     = 4'd1;
    localparam logic [3:0] S_RW2     = 4'd2;
    localparam logic [3:0] S_RW3     = 4'd3;
    localparam logic [3:0] S_RW4     = 4'd4;
    localparam logic [3:0] S_CASWAIT = 4'd5;
    localparam logic [3:0] S_RW5     = 4'd6;
    localparam logic [3:0] S_REF1    = 4'd7;
    localparam logic [3:0] S_REF2    = 4'd8;
    localparam logic [3:0] S_REF3    = 4'd9;
    localparam logic [3:0] S_REF4    = 4'd10;
    localparam logic [3:0] S_ERR     = 4'd11;
    localparam logic [3:0] S_PRE     = 4'd12;

    logic [3:0]         state_q, state_d;
    logic [RC_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic [1:0]         pending_q, pending_d;
    logic               as_used_q, as_used_d;
    logic [1:0]         wait_cnt_q, wait_cnt_d;
    logic [1:0]         pre_cnt_q, pre_cnt_d;
    logic [MA_BITS-1:0] row_q, row_d, col_q, col_d;
    logic [3:0]         en_q, en_d;
    logic               rnw_q, rnw_d;
    logic [NR-1:0]      ras_sel_q, ras_sel_d;
    logic               nwr_q, nwr_d;
    logic [MA_BITS-1:0] addr_q, addr_d;
    logic [NR-1:0]      nras_q, nras_d;
    logic [3:0]         ncas_q, ncas_d;
    logic               dsack_q, dsack_d;
    logic               berr_q, berr_d;

    logic [BANK_W-1:0]  bank, simm;
    logic               side, in_range, start_req, ref_wrap, ref_take;
    logic [BANK_W+1:0]  ras_shift;
    logic [3:0]         lane_en;

    // Decode the CPU address into bank/SIMM/side and qualify a new access.
    always_comb begin
        bank = bus.ADDR[ADDR_WIDTH-1:BANK_LSB];
        if (SIDES == 2) begin
            simm = bank >> 1;
            side = bank[0];
        end else begin
            simm = bank;
            side = 1'b0;
        end
        ras_shift = {simm, 2'b00} | {{(BANK_W + 1){1'b0}}, side};
        in_range  = ((BANK_W + 4)'(bank) < NBANKS);
        start_req = !bus.nCS && !bus.nAS && !as_used_q;
        ref_wrap  = (ref_cnt_q == RC_LAST);
    end

    // Byte lanes for a 32-bit port; reads always fetch the whole longword.
    always_comb begin
        lane_en = 4'b1111;
        if (!bus.RnW) begin
            case ({bus.SIZ1, bus.SIZ0, bus.ADDR[1:0]})
                4'b0000: lane_en = 4'b1111;
                4'b0001: lane_en = 4'b0111;
                4'b0010: lane_en = 4'b0011;
                4'b0011: lane_en = 4'b0001;
                4'b0100: lane_en = 4'b1000;
                4'b0101: lane_en = 4'b0100;
                4'b0110: lane_en = 4'b0010;
                4'b0111: lane_en = 4'b0001;
                4'b1000: lane_en = 4'b1100;
                4'b1001: lane_en = 4'b0110;
                4'b1010: lane_en = 4'b0011;
                4'b1011: lane_en = 4'b0001;
                4'b1100: lane_en = 4'b1110;
                4'b1101: lane_en = 4'b0111;
                4'b1110: lane_en = 4'b0011;
                4'b1111: lane_en = 4'b0001;
            endcase
        end
    end

    // Refresh interval timer and saturating count of owed refreshes.
    always_comb begin
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RC_W'(1);
        pending_d = pending_q;
        if (ref_wrap && !ref_take) begin
            if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
        end else if (!ref_wrap && ref_take) begin
            pending_d = pending_q - 2'd1;
        end
    end

    // Sequencer: next state and next values of all registered strobes.
    always_comb begin
        state_d    = state_q;
        as_used_d  = as_used_q;
        wait_cnt_d = '0;
        pre_cnt_d  = '0;
        row_d      = row_q;
        col_d      = col_q;
        en_d       = en_q;
        rnw_d      = rnw_q;
        ras_sel_d  = ras_sel_q;
        nwr_d      = nwr_q;
        addr_d     = addr_q;
        nras_d     = nras_q;
        ncas_d     = ncas_q;
        dsack_d    = dsack_q;
        berr_d     = berr_q;
        ref_take   = 1'b0;

        // A completed cycle must see nAS rise before another access may start.
        if (bus.nAS) as_used_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != 2'd0) begin
                    state_d  = S_REF1;
                    ref_take = 1'b1;
                end else if (start_req) begin
                    as_used_d = 1'b1;
                    if (in_range) begin
                        state_d   = S_RW1;
                        row_d     = bus.ADDR[MA_BITS+1:2];
                        col_d     = bus.ADDR[2*MA_BITS+1:MA_BITS+2];
                        en_d      = lane_en;
                        rnw_d     = bus.RnW;
                        ras_sel_d = NR'(3'b101) << ras_shift;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_RW1: begin
                if (bus.nAS) state_d = S_PRE;
                else begin
                    addr_d  = row_q;
                    state_d = S_RW2;
                end
            end
            S_RW2: begin
                if (bus.nAS) state_d = S_PRE;
                else begin
                    nras_d  = ~ras_sel_q;
                    state_d = S_RW3;
                end
            end
            S_RW3: begin
                if (bus.nAS) state_d = S_PRE;
                else begin
                    addr_d  = col_q;
                    nwr_d   = rnw_q;
                    state_d = S_RW4;
                end
            end
            S_RW4: begin
                if (bus.nAS) state_d = S_PRE;
                else begin
                    ncas_d  = ~en_q;
                    state_d = (CAS_WAIT == 0) ? S_RW5 : S_CASWAIT;
                end
            end
            S_CASWAIT: begin
                if (bus.nAS) state_d = S_PRE;
                else if (wait_cnt_q == CW_LAST) state_d = S_RW5;
                else wait_cnt_d = wait_cnt_q + 2'd1;
            end
            S_RW5: begin
                dsack_d = 1'b1;
                if (bus.nAS) state_d = S_PRE;
            end
            S_REF1: begin
                nwr_d   = 1'b1;
                ncas_d  = 4'b0000;
                state_d = S_REF2;
            end
            S_REF2: begin
                nras_d  = '0;
                state_d = S_REF3;
            end
            S_REF3: begin
                ncas_d  = 4'b1111;
                state_d = S_REF4;
            end
            S_REF4: begin
                nras_d  = '1;
                state_d = S_PRE;
            end
            S_ERR: begin
                if (bus.nAS) begin
                    berr_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    berr_d = 1'b1;
                end
            end
            S_PRE: begin
                nras_d  = '1;
                ncas_d  = 4'b1111;
                nwr_d   = 1'b1;
                addr_d  = '0;
                dsack_d = 1'b0;
                if (pre_cnt_q == PC_LAST) state_d = S_IDLE;
                else pre_cnt_d = pre_cnt_q + 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset parks every strobe inactive.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            ref_cnt_q  <= '0;
            pending_q  <= 2'd0;
            as_used_q  <= 1'b0;
            wait_cnt_q <= 2'd0;
            pre_cnt_q  <= 2'd0;
            row_q      <= '0;
            col_q      <= '0;
            en_q       <= 4'b0000;
            rnw_q      <= 1'b1;
            ras_sel_q  <= '0;
            nwr_q      <= 1'b1;
            addr_q     <= '0;
            nras_q     <= '1;
            ncas_q     <= 4'b1111;
            dsack_q    <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            pending_q  <= pending_d;
            as_used_q  <= as_used_d;
            wait_cnt_q <= wait_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            en_q       <= en_d;
            rnw_q      <= rnw_d;
            ras_sel_q  <= ras_sel_d;
            nwr_q      <= nwr_d;
            addr_q     <= addr_d;
            nras_q     <= nras_d;
            ncas_q     <= ncas_d;
            dsack_q    <= dsack_d;
            berr_q     <= berr_d;
        end
    end

    assign bus.DRAM_nWR  = nwr_q;
    assign bus.DRAM_ADDR = addr_q;
    assign bus.DRAM_nRAS = nras_q;
    assign bus.DRAM_nCAS = ncas_q;
    assign bus.DSACK0    = dsack_q;
    assign bus.DSACK1    = dsack_q;
    assign bus.BERR      = berr_q;
endmodule

// File: tb/tb_dramctl_multi.sv
// Bench for dramctl_multi: unit A uses defaults (2 SIMMs x 2 sides, no CAS wait),
// unit B is 2 SIMMs x 1 side with CAS_WAIT=2. Both share the same CPU bus inputs.
module tb_dramctl_multi;
    logic clk;
    logic nrst;
    logic mon_b;
    int   cyc;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic        berr;
        logic [7:0]  nras;
        logic [3:0]  ncas;
        logic        nwr;
        logic [11:0] row;
        logic [11:0] col;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    dramctl_multi_if #(.ADDR_WIDTH(28), .MA_BITS(12), .NUM_SIMMS(2)) bus_a ();
    dramctl_multi_if #(.ADDR_WIDTH(28), .MA_BITS(12), .NUM_SIMMS(2)) bus_b ();

    assign bus_b.nCS  = bus_a.nCS;
    assign bus_b.RnW  = bus_a.RnW;
    assign bus_b.nAS  = bus_a.nAS;
    assign bus_b.SIZ0 = bus_a.SIZ0;
    assign bus_b.SIZ1 = bus_a.SIZ1;
    assign bus_b.ADDR = bus_a.ADDR;

    dramctl_multi #(
        .ADDR_WIDTH(28), .MA_BITS(12), .NUM_SIMMS(2), .SIDES(2),
        .REFRESH_CNT(375), .CAS_WAIT(0), .PRECHARGE_CYCLES(1)
    ) u_dut_a (
        .CLK(clk), .nRST(nrst), .bus(bus_a)
    );

    dramctl_multi #(
        .ADDR_WIDTH(28), .MA_BITS(12), .NUM_SIMMS(2), .SIDES(1),
        .REFRESH_CNT(375), .CAS_WAIT(2), .PRECHARGE_CYCLES(1)
    ) u_dut_b (
        .CLK(clk), .nRST(nrst), .bus(bus_b)
    );

    wire [7:0]  m_nras   = mon_b ? bus_b.DRAM_nRAS : bus_a.DRAM_nRAS;
    wire [3:0]  m_ncas   = mon_b ? bus_b.DRAM_nCAS : bus_a.DRAM_nCAS;
    wire [11:0] m_addr   = mon_b ? bus_b.DRAM_ADDR : bus_a.DRAM_ADDR;
    wire        m_nwr    = mon_b ? bus_b.DRAM_nWR  : bus_a.DRAM_nWR;
    wire        m_dsack0 = mon_b ? bus_b.DSACK0    : bus_a.DSACK0;
    wire        m_dsack1 = mon_b ? bus_b.DSACK1    : bus_a.DSACK1;
    wire        m_berr   = mon_b ? bus_b.BERR      : bus_a.BERR;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Lane model: bytes covered from offset A1:A0 for the transfer size, clipped at the port edge.
    function automatic logic [3:0] model_en(input logic rnw, input logic [1:0] siz, input logic [1:0] a);
        logic [3:0] e;
        int n;
        int hi;
        e = 4'b0000;
        if (rnw) return 4'b1111;
        n  = (siz == 2'b00) ? 4 : int'(siz);
        hi = int'(a) + n - 1;
        if (hi > 3) hi = 3;
        for (int i = int'(a); i <= hi; i++) e[3-i] = 1'b1;
        return e;
    endfunction

    task automatic wait_safe();
        while ((cyc % 375) < 10 || (cyc % 375) > 330) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input logic [27:0] addr, input logic rnw, input logic [1:0] siz);
        bus_a.ADDR = addr;
        bus_a.RnW  = rnw;
        bus_a.SIZ1 = siz[1];
        bus_a.SIZ0 = siz[0];
        bus_a.nCS  = 1'b0;
        bus_a.nAS  = 1'b0;
    endtask

    task automatic access(input logic use_b, input logic [27:0] addr, input logic rnw,
                          input logic [1:0] siz, input int extra);
        exp_t e;
        int nb, sides, cw, bank, simm, side, lat;
        logic got_ack, got_berr, ras_seen, cas_seen, act, rel;
        logic [7:0]  o_nras;
        logic [11:0] o_row, o_col;
        logic [3:0]  o_ncas;
        logic        o_nwr;

        nb    = use_b ? 2 : 4;
        sides = use_b ? 1 : 2;
        cw    = use_b ? 2 : 0;
        bank  = int'(addr[27:26]);
        simm  = bank / sides;
        side  = bank % sides;
        e.berr = (bank >= nb);
        e.nras = 8'hFF;
        if (!e.berr) begin
            e.nras[4*simm+side]   = 1'b0;
            e.nras[4*simm+side+2] = 1'b0;
        end
        e.ncas = ~model_en(rnw, siz, addr[1:0]);
        e.nwr  = rnw;
        e.row  = addr[13:2];
        e.col  = addr[25:14];
        e.lat  = e.berr ? 1 : 5 + cw + extra;
        sb_q.push_back(e);

        mon_b = use_b;
        drive(addr, rnw, siz);

        got_ack = 0; got_berr = 0; ras_seen = 0; cas_seen = 0; act = 0; lat = -1;
        o_nras = 8'h00; o_row = 12'h0; o_col = 12'h0; o_ncas = 4'h0; o_nwr = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (!ras_seen && m_nras != 8'hFF && m_nras != 8'h00) begin
                ras_seen = 1; o_nras = m_nras; o_row = m_addr;
            end
            if (!cas_seen && m_ncas != 4'hF && m_nras != 8'hFF && m_nras != 8'h00) begin
                cas_seen = 1; o_ncas = m_ncas; o_col = m_addr; o_nwr = m_nwr;
            end
            if (m_nras != 8'hFF || m_ncas != 4'hF) act = 1;
            if (m_dsack0 || m_berr) begin
                got_ack = m_dsack0; got_berr = m_berr; lat = i;
                break;
            end
        end

        e = sb_q.pop_front();
        chk("berr", got_berr, e.berr);
        chk("dsack0", got_ack, !e.berr);
        chk("dsack1", m_dsack1, !e.berr);
        chk("latency", lat, e.lat);
        if (e.berr) begin
            chk("berr_no_strobes", act, 1'b0);
        end else begin
            chk("ras_lines", o_nras, e.nras);
            chk("row_addr", o_row, e.row);
            chk("cas_lanes", o_ncas, e.ncas);
            chk("col_addr", o_col, e.col);
            chk("nwr", o_nwr, e.nwr);
        end

        bus_a.nAS = 1'b1;
        bus_a.nCS = 1'b1;
        rel = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!m_dsack0 && !m_berr) begin
                rel = 1;
                break;
            end
        end
        chk("release", rel, 1'b1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        logic found, saw_ack;
        logic [27:0] ra;
        n_chk = 0;
        n_fail = 0;
        mon_b = 0;
        nrst = 1'b0;
        bus_a.nCS = 1'b1; bus_a.nAS = 1'b1; bus_a.RnW = 1'b1;
        bus_a.SIZ0 = 1'b0; bus_a.SIZ1 = 1'b0; bus_a.ADDR = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_nras", bus_a.DRAM_nRAS, 8'hFF);
        chk("rst_ncas", bus_a.DRAM_nCAS, 4'hF);
        chk("rst_nwr", bus_a.DRAM_nWR, 1'b1);
        chk("rst_addr", bus_a.DRAM_ADDR, 12'h000);
        chk("rst_dsack", {bus_a.DSACK1, bus_a.DSACK0}, 2'b00);
        chk("rst_berr", bus_a.BERR, 1'b0);
        chk("rst_b_nras", bus_b.DRAM_nRAS, 8'hFF);
        @(negedge clk);
        nrst = 1'b1;

        // Idle refresh: CAS-before-RAS around the first timer wrap.
        found = 0; saw_ack = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (bus_a.DSACK0 || bus_a.DSACK1) saw_ack = 1;
            if (bus_a.DRAM_nCAS == 4'h0) begin
                found = 1;
                break;
            end
        end
        chk("ref_found", found, 1'b1);
        chk("ref_window", (cyc >= 375 && cyc <= 377), 1'b1);
        chk("ref_cas_first", bus_a.DRAM_nRAS, 8'hFF);
        @(posedge clk); #1;
        chk("ref_ras_all", bus_a.DRAM_nRAS, 8'h00);
        chk("ref_cas_held", bus_a.DRAM_nCAS, 4'h0);
        @(posedge clk); #1;
        chk("ref_cas_up", bus_a.DRAM_nCAS, 4'hF);
        chk("ref_ras_held", bus_a.DRAM_nRAS, 8'h00);
        @(posedge clk); #1;
        chk("ref_ras_up", bus_a.DRAM_nRAS, 8'hFF);
        chk("ref_no_dsack", saw_ack | bus_a.DSACK0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        wait_safe(); access(1'b0, 28'h0000100, 1'b1, 2'b00, 0);
        wait_safe(); access(1'b0, 28'h4000003, 1'b0, 2'b01, 0);
        wait_safe(); access(1'b0, 28'hC0A5006, 1'b0, 2'b10, 0);
        wait_safe(); access(1'b0, 28'h8123455, 1'b0, 2'b11, 0);
        for (int j = 0; j < 6; j++) begin
            ra = 28'($urandom());
            wait_safe();
            access(1'b0, ra, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0);
        end
        wait_safe(); access(1'b1, 28'h8000000, 1'b1, 2'b00, 0);
        wait_safe(); access(1'b1, 28'h4000100, 1'b1, 2'b00, 0);

        // Access arriving with a refresh already owed: refresh, precharge, then the cycle.
        while ((cyc % 375) != 0) begin
            @(posedge clk); #1;
        end
        access(1'b0, 28'h0000200, 1'b1, 2'b00, 6);

        // Abort after RAS is down: no DSACK, strobes return idle.
        wait_safe();
        mon_b = 0;
        drive(28'h0000300, 1'b1, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_ras_low", bus_a.DRAM_nRAS, 8'hFA);
        bus_a.nAS = 1'b1;
        bus_a.nCS = 1'b1;
        saw_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus_a.DSACK0 || bus_a.DSACK1) saw_ack = 1;
        end
        chk("abort_no_dsack", saw_ack, 1'b0);
        chk("abort_ras_idle", bus_a.DRAM_nRAS, 8'hFF);
        chk("abort_cas_idle", bus_a.DRAM_nCAS, 4'hF);

        // Asynchronous reset while CAS is low.
        wait_safe();
        drive(28'h0000100, 1'b1, 2'b00);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_a.DRAM_nCAS != 4'hF) begin
                found = 1;
                break;
            end
        end
        chk("arst_cas_low", found, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_nras", bus_a.DRAM_nRAS, 8'hFF);
        chk("arst_ncas", bus_a.DRAM_nCAS, 4'hF);
        chk("arst_nwr", bus_a.DRAM_nWR, 1'b1);
        chk("arst_addr", bus_a.DRAM_ADDR, 12'h000);
        chk("arst_dsack", {bus_a.DSACK1, bus_a.DSACK0}, 2'b00);
        chk("arst_berr", bus_a.BERR, 1'b0);
        bus_a.nAS = 1'b1;
        bus_a.nCS = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
